// File: rtl/reorder_channel.sv
// reorder_channel
//   Per-channel reorder stage behind requantize. Streams the 576 samples of a
//   granule out of the granule RAM (sequential reads, 1-cycle read latency) and
//   writes them into the reorder RAM. Short-block granules are rearranged from
//   window-major to frequency-major order inside each short sfb; mixed blocks
//   copy samples 0..35 and reorder from short sfb 3 upward; everything else is
//   a straight copy.
//
//   Ports
//     clk, rst_n                      clock, asynchronous active-low reset
//     granule_read_addr  (out)        sample read address
//     granule_read_data  (in)         sample, valid the cycle after its address
//     reorder_write_enable/addr/data  reorder RAM write port
//     header_sampling_frequency (in)  0=44.1k 1=48k 2=32k 3=44.1k
//     sideinfo_block_type, sideinfo_window_switching_flag,
//     sideinfo_mixed_block_flag (in)  granule side info, sampled at start
//     channel_ready      (in)         start pulse, ignored unless idle
//     channel_done       (out)        one-cycle completion pulse
//     reordered          (out)        reorder RAM holds the last granule
//
//   Optional build macro: REORDER_PASSTHRU_EN -- non-short granules skip all
//   RAM traffic, finish two cycles after start and leave reordered low.

module reorder_channel #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 18,
  parameter int SAMPLES = 576
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] granule_read_addr,
  input  logic [DATA_W-1:0] granule_read_data,
  output logic              reorder_write_enable,
  output logic [ADDR_W-1:0] reorder_write_addr,
  output logic [DATA_W-1:0] reorder_write_data,
  input  logic [1:0]        header_sampling_frequency,
  input  logic [1:0]        sideinfo_block_type,
  input  logic              sideinfo_window_switching_flag,
  input  logic              sideinfo_mixed_block_flag,
  input  logic              channel_ready,
  output logic              channel_done,
  output logic              reordered
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SAMPLES - 1);
  localparam logic [ADDR_W-1:0] MIX_END   = ADDR_W'(36);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t            state_q;
  logic [1:0]        sf_q;
  logic              short_q;
  logic              mixed_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              we_q;
  logic              done_q;
  logic              reordered_q;
  logic [3:0]        sfb_q;
  logic [1:0]        win_q;
  logic [ADDR_W-1:0] i_q;
  logic [ADDR_W-1:0] base_q;
`ifdef REORDER_PASSTHRU_EN
  logic              pass_q;
`endif

  logic              copy_c;
  logic [ADDR_W-1:0] width_c;
  logic [ADDR_W-1:0] wa_c;

  // Short-block sfb start indices (per window); entry 13 is the end (192).
  function automatic logic [7:0] sfb_start(input logic [1:0] sf, input logic [3:0] sfb);
    logic [7:0] s;
    s = 8'd192;
    case (sf)
      2'd1: case (sfb)
              4'd0: s = 8'd0;    4'd1: s = 8'd4;    4'd2: s = 8'd8;
              4'd3: s = 8'd12;   4'd4: s = 8'd16;   4'd5: s = 8'd22;
              4'd6: s = 8'd28;   4'd7: s = 8'd38;   4'd8: s = 8'd50;
              4'd9: s = 8'd64;   4'd10: s = 8'd80;  4'd11: s = 8'd100;
              4'd12: s = 8'd126; default: s = 8'd192;
            endcase
      2'd2: case (sfb)
              4'd0: s = 8'd0;    4'd1: s = 8'd4;    4'd2: s = 8'd8;
              4'd3: s = 8'd12;   4'd4: s = 8'd16;   4'd5: s = 8'd22;
              4'd6: s = 8'd30;   4'd7: s = 8'd42;   4'd8: s = 8'd58;
              4'd9: s = 8'd78;   4'd10: s = 8'd104; 4'd11: s = 8'd138;
              4'd12: s = 8'd180; default: s = 8'd192;
            endcase
      default: case (sfb)
              4'd0: s = 8'd0;    4'd1: s = 8'd4;    4'd2: s = 8'd8;
              4'd3: s = 8'd12;   4'd4: s = 8'd16;   4'd5: s = 8'd22;
              4'd6: s = 8'd30;   4'd7: s = 8'd40;   4'd8: s = 8'd52;
              4'd9: s = 8'd66;   4'd10: s = 8'd84;  4'd11: s = 8'd106;
              4'd12: s = 8'd136; default: s = 8'd192;
            endcase
    endcase
    return s;
  endfunction

  // The sfb/win/i counters track the address currently held in rd_addr_q.
  // Because i runs fastest, then win, then sfb, the short-mode read address
  // sfb_base + win*width + i is itself sequential, so only the write address
  // needs the counters.
  always_comb begin
    copy_c  = !short_q || (mixed_q && (rd_addr_q < MIX_END));
    width_c = ADDR_W'(sfb_start(sf_q, sfb_q + 4'd1) - sfb_start(sf_q, sfb_q));
    wa_c    = copy_c ? rd_addr_q
                     : base_q + ADDR_W'(3) * i_q + ADDR_W'(win_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sf_q        <= '0;
      short_q     <= 1'b0;
      mixed_q     <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      reordered_q <= 1'b0;
      sfb_q       <= '0;
      win_q       <= '0;
      i_q         <= '0;
      base_q      <= '0;
`ifdef REORDER_PASSTHRU_EN
      pass_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          we_q <= 1'b0;
          if (channel_ready) begin
            sf_q        <= (header_sampling_frequency == 2'd3) ? 2'd0 : header_sampling_frequency;
            short_q     <= sideinfo_window_switching_flag && (sideinfo_block_type == 2'd2);
            mixed_q     <= sideinfo_window_switching_flag && (sideinfo_block_type == 2'd2)
                           && sideinfo_mixed_block_flag;
            rd_addr_q   <= '0;
            i_q         <= '0;
            win_q       <= '0;
            // Mixed blocks park the counters at sfb 3 until the copy region ends.
            sfb_q       <= sideinfo_mixed_block_flag ? 4'd3 : 4'd0;
            base_q      <= sideinfo_mixed_block_flag ? MIX_END : '0;
            reordered_q <= 1'b0;
`ifdef REORDER_PASSTHRU_EN
            pass_q  <= !(sideinfo_window_switching_flag && (sideinfo_block_type == 2'd2));
            state_q <= (sideinfo_window_switching_flag && (sideinfo_block_type == 2'd2))
                       ? S_RUN : S_FLUSH;
`else
            state_q <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          we_q      <= 1'b1;
          wr_addr_q <= wa_c;
          if (rd_addr_q == LAST_ADDR) begin
            state_q <= S_FLUSH;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
          if (!copy_c) begin
            if (i_q == width_c - ADDR_W'(1)) begin
              i_q <= '0;
              if (win_q == 2'd2) begin
                win_q  <= '0;
                sfb_q  <= sfb_q + 4'd1;
                base_q <= base_q + ADDR_W'(3) * width_c;
              end else begin
                win_q <= win_q + 2'd1;
              end
            end else begin
              i_q <= i_q + ADDR_W'(1);
            end
          end
        end
        S_FLUSH: begin
          we_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
`ifdef REORDER_PASSTHRU_EN
          reordered_q <= !pass_q;
`else
          reordered_q <= 1'b1;
`endif
        end
        default: begin
          we_q    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign granule_read_addr    = rd_addr_q;
  assign reorder_write_enable = we_q;
  assign reorder_write_addr   = wr_addr_q;
  // Read data arrives the cycle the write is issued, so it goes straight through.
  assign reorder_write_data   = we_q ? granule_read_data : '0;
  assign channel_done         = done_q;
  assign reordered            = reordered_q;

endmodule

// File: tb/tb_reorder_channel.sv
// Directed bench for reorder_channel: models the granule RAM (in[k]=k, 1-cycle
// read latency) and the reorder RAM, and checks hand-computed vectors.

module tb_reorder_channel;

  logic        clk;
  logic        rst_n;
  logic [9:0]  granule_read_addr;
  logic [17:0] granule_read_data;
  logic        reorder_write_enable;
  logic [9:0]  reorder_write_addr;
  logic [17:0] reorder_write_data;
  logic [1:0]  header_sampling_frequency;
  logic [1:0]  sideinfo_block_type;
  logic        sideinfo_window_switching_flag;
  logic        sideinfo_mixed_block_flag;
  logic        channel_ready;
  logic        channel_done;
  logic        reordered;

  logic [17:0] gmem [0:1023];
  logic [17:0] omem [0:1023];

  int n_vec;
  int n_err;

  reorder_channel #(.ADDR_W(10), .DATA_W(18), .SAMPLES(576)) dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .granule_read_addr              (granule_read_addr),
    .granule_read_data              (granule_read_data),
    .reorder_write_enable           (reorder_write_enable),
    .reorder_write_addr             (reorder_write_addr),
    .reorder_write_data             (reorder_write_data),
    .header_sampling_frequency      (header_sampling_frequency),
    .sideinfo_block_type            (sideinfo_block_type),
    .sideinfo_window_switching_flag (sideinfo_window_switching_flag),
    .sideinfo_mixed_block_flag      (sideinfo_mixed_block_flag),
    .channel_ready                  (channel_ready),
    .channel_done                   (channel_done),
    .reordered                      (reordered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) granule_read_data <= gmem[granule_read_addr];

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts one granule; ready is sampled at edge 1, so edge n ends cycle n-1
  // and outputs seen after edge n belong to cycle n.
  task automatic run_gran(input logic [1:0] sf, input logic [1:0] bt,
                          input logic wsf, input logic mx,
                          input int repulse_at, input int reset_at,
                          output int done_n, output int done_cnt,
                          output int first_w, output int last_w, output int wcnt);
    for (int k = 0; k < 1024; k++) omem[k] = '1;
    done_n = -1; done_cnt = 0; first_w = -1; last_w = -1; wcnt = 0;
    @(negedge clk);
    header_sampling_frequency      = sf;
    sideinfo_block_type            = bt;
    sideinfo_window_switching_flag = wsf;
    sideinfo_mixed_block_flag      = mx;
    channel_ready                  = 1'b1;
    for (int n = 1; n <= 600; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) channel_ready = 1'b0;
      if (repulse_at > 0 && n == repulse_at - 1) channel_ready = 1'b1;
      if (repulse_at > 0 && n == repulse_at) channel_ready = 1'b0;
      if (reset_at > 0 && n == reset_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_we_async", int'(reorder_write_enable), 0);
      end
      if (channel_done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (reorder_write_enable) begin
        if (first_w < 0) first_w = n;
        last_w = n;
        wcnt++;
        omem[reorder_write_addr] = reorder_write_data;
      end
    end
    if (reset_at > 0) begin
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    int dn, dc, fw, lw, wc, bad;
    n_vec = 0;
    n_err = 0;
    for (int k = 0; k < 1024; k++) gmem[k] = 18'(k);
    rst_n = 1'b0;
    channel_ready = 1'b0;
    header_sampling_frequency = '0;
    sideinfo_block_type = '0;
    sideinfo_window_switching_flag = 1'b0;
    sideinfo_mixed_block_flag = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_raddr", int'(granule_read_addr), 0);
    check("rst_we", int'(reorder_write_enable), 0);
    check("rst_waddr", int'(reorder_write_addr), 0);
    check("rst_wdata", int'(reorder_write_data), 0);
    check("rst_done", int'(channel_done), 0);
    check("rst_reordered", int'(reordered), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Long block: straight copy.
    run_gran(2'd0, 2'd0, 1'b0, 1'b0, 0, 0, dn, dc, fw, lw, wc);
    check("long_done_cycle", dn, 578);
    check("long_done_count", dc, 1);
    check("long_first_write", fw, 2);
    check("long_last_write", lw, 577);
    check("long_write_count", wc, 576);
    check("long_reordered", int'(reordered), 1);
    bad = 0;
    for (int k = 0; k < 576; k++) if (omem[k] != 18'(k)) bad++;
    check("long_data_bad", bad, 0);

    // Short 44.1k, non-mixed.
    run_gran(2'd0, 2'd2, 1'b1, 1'b0, 0, 0, dn, dc, fw, lw, wc);
    check("s44_write_count", wc, 576);
    check("s44_out0", int'(omem[0]), 0);
    check("s44_out1", int'(omem[1]), 4);
    check("s44_out2", int'(omem[2]), 8);
    check("s44_out3", int'(omem[3]), 1);
    check("s44_out4", int'(omem[4]), 5);
    check("s44_out5", int'(omem[5]), 9);
    check("s44_out408", int'(omem[408]), 408);
    check("s44_out409", int'(omem[409]), 464);
    check("s44_out410", int'(omem[410]), 520);

    // Short 32k.
    run_gran(2'd2, 2'd2, 1'b1, 1'b0, 0, 0, dn, dc, fw, lw, wc);
    check("s32_done_cycle", dn, 578);
    check("s32_out540", int'(omem[540]), 540);
    check("s32_out541", int'(omem[541]), 552);
    check("s32_out542", int'(omem[542]), 564);
    check("s32_out575", int'(omem[575]), 575);

    // Mixed 48k.
    run_gran(2'd1, 2'd2, 1'b1, 1'b1, 0, 0, dn, dc, fw, lw, wc);
    bad = 0;
    for (int k = 0; k < 36; k++) if (omem[k] != 18'(k)) bad++;
    check("mix_copy_bad", bad, 0);
    check("mix_out36", int'(omem[36]), 36);
    check("mix_out37", int'(omem[37]), 40);
    check("mix_out38", int'(omem[38]), 44);
    check("mix_write_count", wc, 576);

    // Start re-pulsed mid-run must be ignored.
    run_gran(2'd0, 2'd0, 1'b0, 1'b0, 100, 0, dn, dc, fw, lw, wc);
    check("repulse_done_cycle", dn, 578);
    check("repulse_done_count", dc, 1);
    check("repulse_write_count", wc, 576);

    // Reset mid-run: no done, then a clean full run.
    run_gran(2'd0, 2'd0, 1'b0, 1'b0, 0, 300, dn, dc, fw, lw, wc);
    check("reset_done_count", dc, 0);
    check("reset_reordered", int'(reordered), 0);
    run_gran(2'd0, 2'd0, 1'b0, 1'b0, 0, 0, dn, dc, fw, lw, wc);
    check("after_reset_done_cycle", dn, 578);
    check("after_reset_write_count", wc, 576);
    check("after_reset_reordered", int'(reordered), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
